// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the high time (duty) and period of an asynchronous PWM line.
// Optional macro PWM_DEC_AVG_EN publishes the mean of the last four high-time samples.
module pwm_duty_decoder #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             Enable_SW_2,
    input  logic             pwm_in,
    output logic [6:0]       Duty_Input,
    output logic [CNT_W-1:0] period_out,
    output logic             duty_valid,
    output logic             stuck,
    output logic [1:0]       o_dbg_state
);

    // duty_valid is a one-cycle strobe with no ready; Duty_Input/period_out hold between strobes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_per_cnt;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_hi_inc;
    logic [CNT_W-1:0] w_per_inc;
    logic [6:0]       w_hi_sat;
    logic [6:0]       w_stuck_duty;
    logic             w_to;
    logic             w_publish;
    logic             w_pub_valid;
    logic [6:0]       w_pub_duty;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= pwm_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_rise       = r_sync2 & ~r_sync_d;
    assign w_fall       = ~r_sync2 & r_sync_d;
    assign w_hi_inc     = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
    assign w_per_inc    = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_W'(1);
    assign w_hi_sat     = (r_hi_cnt > CNT_W'(127)) ? 7'd127 : r_hi_cnt[6:0];
    assign w_stuck_duty = r_sync2 ? 7'd127 : 7'd0;

    // An edge in the timeout cycle wins; a stuck IDLE stops counting until the next edge.
    assign w_to = Enable_SW_2 && !w_rise && (r_per_cnt >= TIMEOUT_C) &&
                  ((r_state != IDLE) || !stuck);
    assign w_publish = Enable_SW_2 && (r_state == LOW) && w_rise;

`ifdef PWM_DEC_AVG_EN
    // Window = incoming sample plus the three most recent held samples.
    logic [2:0][6:0] r_hist;
    logic [1:0]      r_hist_cnt;
    logic [8:0]      w_avg_sum;

    assign w_avg_sum   = 9'(w_hi_sat) + 9'(r_hist[0]) + 9'(r_hist[1]) + 9'(r_hist[2]);
    assign w_pub_duty  = 7'(w_avg_sum >> 2);
    assign w_pub_valid = (r_hist_cnt == 2'd3);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist     <= '0;
            r_hist_cnt <= 2'd0;
        end else if (!Enable_SW_2 || w_to) begin
            r_hist     <= '0;
            r_hist_cnt <= 2'd0;
        end else if (w_publish) begin
            r_hist     <= {r_hist[1:0], w_hi_sat};
            r_hist_cnt <= (r_hist_cnt == 2'd3) ? 2'd3 : r_hist_cnt + 2'd1;
        end
    end
`else
    assign w_pub_duty  = w_hi_sat;
    assign w_pub_valid = w_publish;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hi_cnt   <= '0;
            r_per_cnt  <= '0;
            Duty_Input <= 7'd0;
            period_out <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (!Enable_SW_2) begin
                r_state   <= IDLE;
                r_hi_cnt  <= '0;
                r_per_cnt <= '0;
            end else if (w_to) begin
                r_state    <= IDLE;
                r_hi_cnt   <= '0;
                r_per_cnt  <= '0;
                stuck      <= 1'b1;
                duty_valid <= 1'b1;
                Duty_Input <= w_stuck_duty;
                period_out <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state   <= HIGH;
                            r_hi_cnt  <= CNT_W'(1);
                            r_per_cnt <= CNT_W'(1);
                            stuck     <= 1'b0;
                        end else if (!stuck) begin
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    HIGH: begin
                        if (w_fall) begin
                            r_state   <= LOW;
                            r_per_cnt <= w_per_inc;
                        end else begin
                            r_hi_cnt  <= w_hi_inc;
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            r_state   <= HIGH;
                            r_hi_cnt  <= CNT_W'(1);
                            r_per_cnt <= CNT_W'(1);
                            if (w_pub_valid) begin
                                duty_valid <= 1'b1;
                                Duty_Input <= w_pub_duty;
                                period_out <= r_per_cnt;
                            end
                        end else begin
                            r_per_cnt <= w_per_inc;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: vector table of PWM shapes plus hand-written
// sequences for timeout, stuck recovery, mid-cycle reset and enable gating.
module tb_pwm_duty_decoder;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b1;
    logic       pwm    = 1'b0;
    logic [6:0] duty;
    logic [7:0] period;
    logic       duty_valid;
    logic       stuck;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Publication record: {stuck, duty, period}
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    typedef struct {
        int         hi;
        int         lo;
        int         reps;
        logic [6:0] exp_duty;
        logic [7:0] exp_per;
    } vec_t;

    vec_t vecs[8];

    always #5 sysclk = ~sysclk;

    pwm_duty_decoder #(.CNT_W(8), .TIMEOUT(200)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .Enable_SW_2 (en),
        .pwm_in      (pwm),
        .Duty_Input  (duty),
        .period_out  (period),
        .duty_valid  (duty_valid),
        .stuck       (stuck),
        .o_dbg_state (dbg_state)
    );

    always @(negedge sysclk) begin
        if (duty_valid) got_q.push_back({stuck, duty, period});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_pubs(input string name);
        check({name, " pub count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({name, " pub"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst_n = 1'b0;
        pwm   = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pwm_cycle(input int hi, input int lo);
        pwm = 1'b1;
        repeat (hi) @(negedge sysclk);
        pwm = 1'b0;
        repeat (lo) @(negedge sysclk);
    endtask

    task automatic final_rise();
        pwm = 1'b1;
        repeat (8) @(negedge sysclk);
    endtask

    initial begin
        // Reset values, then a line held low until it times out
        @(negedge sysclk);
        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        check("reset duty", 32'(duty), 32'd0);
        check("reset period", 32'(period), 32'd0);
        check("reset valid", 32'(duty_valid), 32'd0);
        check("reset stuck", 32'(stuck), 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        repeat (195) @(negedge sysclk);
        check("stuck before timeout", 32'(stuck), 32'd0);
        repeat (15) @(negedge sysclk);
        check("stuck after timeout", 32'(stuck), 32'd1);
        repeat (90) @(negedge sysclk);
        exp_q.push_back({1'b1, 7'd0, 8'd0});
        check_pubs("low timeout");
        check("stuck held", 32'(stuck), 32'd1);

`ifndef PWM_DEC_AVG_EN
        vecs[0] = '{hi: 30,  lo: 70,  reps: 3, exp_duty: 7'd30,  exp_per: 8'd100};
        vecs[1] = '{hi: 150, lo: 20,  reps: 2, exp_duty: 7'd127, exp_per: 8'd170};
        vecs[2] = '{hi: 40,  lo: 60,  reps: 2, exp_duty: 7'd40,  exp_per: 8'd100};
        vecs[3] = '{hi: 1,   lo: 5,   reps: 3, exp_duty: 7'd1,   exp_per: 8'd6};
        vecs[4] = '{hi: 5,   lo: 1,   reps: 3, exp_duty: 7'd5,   exp_per: 8'd6};
        vecs[5] = '{hi: 127, lo: 10,  reps: 2, exp_duty: 7'd127, exp_per: 8'd137};
        vecs[6] = '{hi: 128, lo: 10,  reps: 2, exp_duty: 7'd127, exp_per: 8'd138};
        vecs[7] = '{hi: 100, lo: 100, reps: 2, exp_duty: 7'd100, exp_per: 8'd200};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int r = 0; r < vecs[v].reps; r++) pwm_cycle(vecs[v].hi, vecs[v].lo);
            final_rise();
            for (int r = 0; r < vecs[v].reps; r++)
                exp_q.push_back({1'b0, vecs[v].exp_duty, vecs[v].exp_per});
            check_pubs($sformatf("vec%0d", v));
            check($sformatf("vec%0d stuck", v), 32'(stuck), 32'd0);
        end

        // Line held high after valid cycles, then recovery on the next rising edge
        do_reset();
        pwm_cycle(30, 70);
        pwm_cycle(30, 70);
        pwm = 1'b1;
        repeat (250) @(negedge sysclk);
        exp_q.push_back({1'b0, 7'd30, 8'd100});
        exp_q.push_back({1'b0, 7'd30, 8'd100});
        exp_q.push_back({1'b1, 7'd127, 8'd0});
        check_pubs("high timeout");
        check("high stuck", 32'(stuck), 32'd1);
        check("high stuck duty", 32'(duty), 32'd127);
        pwm = 1'b0;
        repeat (20) @(negedge sysclk);
        check("stuck through fall", 32'(stuck), 32'd1);
        pwm = 1'b1;
        repeat (8) @(negedge sysclk);
        check("stuck cleared", 32'(stuck), 32'd0);
        check_pubs("recovery edge");

        // Reset in the middle of a high phase
        do_reset();
        pwm_cycle(40, 60);
        pwm_cycle(40, 60);
        pwm = 1'b1;
        repeat (20) @(negedge sysclk);
        check("pre-reset duty", 32'(duty), 32'd40);
        exp_q.push_back({1'b0, 7'd40, 8'd100});
        exp_q.push_back({1'b0, 7'd40, 8'd100});
        check_pubs("pre-reset");
        rst_n = 1'b0;
        repeat (20) @(negedge sysclk);
        pwm = 1'b0;
        repeat (2) @(negedge sysclk);
        check("mid reset duty", 32'(duty), 32'd0);
        check("mid reset period", 32'(period), 32'd0);
        check("mid reset state", 32'(dbg_state), 32'd0);
        repeat (8) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (50) @(negedge sysclk);
        pwm_cycle(40, 60);
        pwm_cycle(40, 60);
        final_rise();
        exp_q.push_back({1'b0, 7'd40, 8'd100});
        exp_q.push_back({1'b0, 7'd40, 8'd100});
        check_pubs("post-reset");

        // Enable low: no publishes, outputs hold, no timeout
        do_reset();
        pwm_cycle(30, 70);
        pwm_cycle(30, 70);
        final_rise();
        exp_q.push_back({1'b0, 7'd30, 8'd100});
        exp_q.push_back({1'b0, 7'd30, 8'd100});
        check_pubs("pre-disable");
        en = 1'b0;
        repeat (22) @(negedge sysclk);
        pwm = 1'b0;
        repeat (70) @(negedge sysclk);
        pwm_cycle(30, 70);
        pwm_cycle(30, 70);
        check_pubs("disabled");
        check("disabled duty", 32'(duty), 32'd30);
        check("disabled period", 32'(period), 32'd100);
        check("disabled stuck", 32'(stuck), 32'd0);
        check("disabled state", 32'(dbg_state), 32'd0);
        en = 1'b1;
        pwm_cycle(30, 70);
        pwm_cycle(30, 70);
        final_rise();
        exp_q.push_back({1'b0, 7'd30, 8'd100});
        exp_q.push_back({1'b0, 7'd30, 8'd100});
        check_pubs("re-enabled");
`else
        // Averaging: first publish after four samples; enable toggle clears history
        do_reset();
        pwm_cycle(20, 80);
        pwm_cycle(40, 60);
        pwm_cycle(60, 40);
        pwm_cycle(80, 20);
        final_rise();
        exp_q.push_back({1'b0, 7'd50, 8'd100});
        check_pubs("avg first");
        en  = 1'b0;
        pwm = 1'b0;
        repeat (10) @(negedge sysclk);
        en = 1'b1;
        repeat (5) @(negedge sysclk);
        for (int r = 0; r < 4; r++) pwm_cycle(40, 60);
        final_rise();
        exp_q.push_back({1'b0, 7'd40, 8'd100});
        check_pubs("avg after clear");
        check("avg stuck", 32'(stuck), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
